data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words stored; power of two, minimum 4.
REQ-002 Parameter LATENCY, default 2: wait cycles inserted between request acceptance and response, range 0..15.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 reset  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req_valid  input  1: initiator presents a request.
REQ-006 req_ready  output  1: responder can accept a request this cycle.
REQ-007 req_we  input  1: 1 = write, 0 = read.
REQ-008 req_addr  input  32: byte address.
REQ-009 req_wdata  input  32: write data.
REQ-010 req_be  input  4: byte enables for writes; bit i enables req_wdata[8i+7:8i]; ignored for reads.
REQ-011 rsp_valid  output  1: response available.
REQ-012 rsp_ready  input  1: initiator accepts the response this cycle.
REQ-013 rsp_rdata  output  32: read data; 0 for writes and error responses.
REQ-014 rsp_err  output  1: response reports a failed access.

Function
REQ-015 States SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; req_we, req_addr, req_wdata and req_be SHALL be captured on that edge.
REQ-017 On acceptance: if LATENCY>0, IDLE SHALL go to WAIT with a 4-bit counter loaded with LATENCY-1; if LATENCY=0, IDLE SHALL go directly to RESP.
REQ-018 In WAIT: the counter SHALL decrement each cycle; WAIT SHALL go to RESP on the edge where the counter is 0.
REQ-019 rsp_valid SHALL rise exactly LATENCY+1 cycles after the accepting edge.
REQ-020 Read data SHALL be sampled and a write SHALL be committed on the edge entering RESP, exactly once per request.
REQ-021 A write SHALL update only the enabled bytes.
REQ-022 The word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-023 In RESP: rsp_valid=1, and rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1.
REQ-024 On the rsp_valid&&rsp_ready edge, RESP SHALL go to IDLE; a new request SHALL be accepted no earlier than the following cycle (no back-to-back overlap).
REQ-025 req_valid deasserting during WAIT or RESP SHALL NOT affect the transaction in progress.
REQ-026 Outside RESP: rsp_valid=0, rsp_rdata=0, rsp_err=0.

Reset
REQ-027 On reset: state=IDLE, counter=0, req_ready=1 on the first cycle after reset, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 Reset during WAIT SHALL abort the request with no write committed.
REQ-029 Reset during RESP SHALL drop the response; any write already committed SHALL stay committed.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro DMEM_ERR_CHECK_EN defined: an access with req_addr[1:0]!=0 or req_addr>=4*DEPTH SHALL respond with rsp_err=1 and rsp_rdata=0, and SHALL make no memory write; latency SHALL be unchanged.
REQ-032 Macro DMEM_ERR_CHECK_EN undefined: rsp_err SHALL be constant 0, req_addr[1:0] SHALL be ignored, and the address SHALL wrap modulo 4*DEPTH.

Verification
REQ-033 LATENCY=2:
- write addr 0x10, wdata 0xDEADBEEF, be 0xF;
- then read 0x10 with rsp_ready=1 -> rsp_valid rises 3 cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-034 Byte enables:
- write 0x20 with 0x11223344, be 0xF;
- then write 0x20 with 0xAABBCCDD, be 0x5;
- then read 0x20 -> 0x11BB33DD.
REQ-035 Response backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; IDLE is entered one cycle after rsp_ready=1.
REQ-036 Reset mid-operation: write 0x30 with 0x12345678 accepted, reset asserted 1 cycle later -> after reset, read 0x30 returns its prior value, rsp_valid=0 immediately after reset.
REQ-037 With DMEM_ERR_CHECK_EN, DEPTH=256:
- write 0x402 -> rsp_err=1, no write;
- write 0x400 -> rsp_err=1, no write.
REQ-038 Without DMEM_ERR_CHECK_EN, DEPTH=256: write 0x400 with 0xCAFEF00D, then read 0x000 -> 0xCAFEF00D, rsp_err=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-outstanding word memory responder with a fixed request-to-response wait.
// Optional macro DMEM_ERR_CHECK_EN enables misalignment/out-of-range error responses.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        enter_resp;

  logic [31:0] mem [DEPTH];

  // With zero latency the access happens on the accepting edge, so the live
  // request fields are used in IDLE and the captured copy everywhere else.
  logic          cur_we;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  logic [AW-1:0] cur_idx;
  logic          cur_err;
  logic          do_write;

  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_be    = (state_q == IDLE) ? req_be    : be_q;
  assign cur_idx   = cur_addr[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;
  assign cur_err = (cur_addr[1:0] != 2'b00) || ({1'b0, cur_addr} >= ADDR_LIMIT);
`else
  logic unused_addr_bits;
  assign cur_err          = 1'b0;
  assign unused_addr_bits = ^{cur_addr[31:AW+2], cur_addr[1:0]};
`endif

  // Next-state process
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (state_q == IDLE && req_valid) begin
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      be_d    = req_be;
    end
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      rdata_d = (!cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
      err_d   = cur_err;
    end
  end

  // A reset on the would-be commit edge wins, so an aborted write never lands.
  assign do_write = enter_resp && cur_we && !cur_err && !reset;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the storage array has no reset, so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

  // Output process
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
    rsp_err   = (state_q == RESP) && err_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, multi-cycle
// corner sequences, and randomized traffic checked against an array model.
module tb_data_mem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] model_mem [DEPTH];

  // Reference: word-addressed array, byte-lane merge on writes, error rules from the address.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] rd, output logic er);
    int idx;
    er = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
    er = ((addr % 4) != 0) || (addr >= 32'(4 * DEPTH));
`endif
    idx = int'((addr >> 2) % DEPTH);
    rd  = 32'd0;
    if (!er) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        rd = model_mem[idx];
      end
    end
  endtask

  // One full transaction; holds rsp_ready low for 'hold' cycles once the response shows.
  task automatic txn(input string name, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check({name, " req_ready timeout"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble the request lines while the transaction is in flight.
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    check({name, " req_ready busy"}, 32'(req_ready), 32'd0);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(LATENCY + 1));
    for (int k = 0; k < hold; k++) begin
      check({name, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({name, " hold rdata"}, rsp_rdata, exp_rdata);
      check({name, " hold req_ready"}, 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, " rdata"}, rsp_rdata, exp_rdata);
    check({name, " err"}, 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, " idle req_ready"}, 32'(req_ready), 32'd1);
    check({name, " idle rdata"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        we;
    int          sel;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);

    // Directed vectors
    vecs.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0});
`ifdef DMEM_ERR_CHECK_EN
    vecs.push_back('{1'b1, 32'h000, 32'h55AA55AA, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 32'h402, 32'h01020304, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h400, 32'h0A0B0C0D, 4'hF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h000, 32'h0, 4'h0, 32'h55AA55AA, 1'b0});
    vecs.push_back('{1'b0, 32'h3FC, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h011, 32'h0, 4'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1});
`else
    vecs.push_back('{1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h000, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{1'b0, 32'h013, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h7FC, 32'h0BADF00D, 4'hC, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h3FC, 32'h0, 4'h0, 32'h0BAD0000, 1'b0});
`endif
    // Word 0x3FC is cleared first so its partial write has a known background.
    txn("clr3fc", 1'b1, 32'h3FC, 32'h0, 4'hF, 0, 32'h0, 1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
          i % 3, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Backpressure: response held for 5 cycles
    txn("bp", 1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEADBEEF, 1'b0);

    // Reset while a write is waiting
    txn("pre30", 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    check("mid accept ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid req_ready", 32'(req_ready), 32'd1);
    txn("mid read30", 1'b0, 32'h30, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 1'b0);

    // Fill every word so later random reads have defined contents
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      model_access(1'b1, 32'(i * 4), d, 4'hF, rd, er);
      txn($sformatf("init%0d", i), 1'b1, 32'(i * 4), d, 4'hF, 0, rd, er);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      a = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (sel < 9) a = 32'($urandom_range(0, 4 * DEPTH - 1));
      else              a = $urandom;
      we = 1'($urandom);
      d  = $urandom;
      be = 4'($urandom);
      model_access(we, a, d, be, rd, er);
      txn($sformatf("rnd%0d", i), we, a, d, be, $urandom_range(0, 3), rd, er);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
